pc_unit_ras: RTL

Parametrised next-generation program counter for the single-issue MIPS core. It adds the following to sequential, jump, register-jump and branch PC update:
- fetch stall
- a configurable return-address stack (RAS) with call/return tracking and mispredict reporting
- optional exception entry/return with an EPC register

It sits between decode/control and the instruction fetch port.

---
 rtl/pc_unit_ras.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pc_unit_ras.sv
// Program counter with fetch stall, a circular return-address stack and
// optional exception entry/return (enabled by defining PC_UNIT_EXC_EN).
module pc_unit_ras #(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
    parameter int          RAS_DEPTH    = 4,
    parameter int          RAS_PTR_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic [2:0]           pc_control,
    input  logic [25:0]          jump_address,
    input  logic [15:0]          branch_offset,
    input  logic [WIDTH-1:0]     reg_address,
    input  logic                 exc_req,
    input  logic                 eret,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     pc_plus_4,
    output logic [WIDTH-1:0]     ras_top,
    output logic [RAS_PTR_W:0]   ras_count,
    output logic                 ras_overflow,
    output logic                 ras_mispredict,
    output logic [WIDTH-1:0]     epc,
    output logic                 in_exception
);

    localparam logic [WIDTH-1:0]     LP_RESET_PC = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0]     LP_EXC_PC   = WIDTH'(EXC_VECTOR);
    localparam logic [RAS_PTR_W:0]   LP_DEPTH    = (RAS_PTR_W+1)'(RAS_DEPTH);
    localparam logic [RAS_PTR_W-1:0] LP_LAST     = RAS_PTR_W'(RAS_DEPTH - 1);

    logic [WIDTH-1:0]     r_pc;
    logic [WIDTH-1:0]     r_ras [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] r_wptr;
    logic [RAS_PTR_W:0]   r_count;
    logic                 r_overflow;
    logic                 r_mispredict;

    logic [WIDTH-1:0]     w_pc_next;
    logic [WIDTH-1:0]     w_jump_target;
    logic [WIDTH-1:0]     w_branch_target;
    logic [RAS_PTR_W-1:0] w_top_idx;
    logic [RAS_PTR_W-1:0] w_wptr_inc;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_mispredict_next;
    logic                 w_exc_take;
    logic                 w_eret_take;

    assign pc             = r_pc;
    assign pc_plus_4      = r_pc + WIDTH'(4);
    assign ras_count      = r_count;
    assign ras_overflow   = r_overflow;
    assign ras_mispredict = r_mispredict;

    generate
        if (WIDTH > 28) begin : g_jump_hi
            assign w_jump_target = {pc_plus_4[WIDTH-1:28], jump_address, 2'b00};
        end else begin : g_jump_lo
            assign w_jump_target = {jump_address, 2'b00};
        end
    endgenerate

    assign w_branch_target = pc_plus_4 + {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};

    // r_wptr is the next write slot; the top entry sits one slot below it, wrapping.
    assign w_top_idx  = (r_wptr == '0)     ? LP_LAST : r_wptr - 1'b1;
    assign w_wptr_inc = (r_wptr == LP_LAST) ? '0     : r_wptr + 1'b1;
    assign ras_top    = (r_count == '0) ? '0 : r_ras[w_top_idx];

`ifdef PC_UNIT_EXC_EN
    logic [WIDTH-1:0] r_epc;
    logic             r_in_exception;

    assign w_exc_take   = exc_req & ~r_in_exception;
    assign w_eret_take  = eret & r_in_exception;
    assign epc          = r_epc;
    assign in_exception = r_in_exception;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epc          <= '0;
            r_in_exception <= 1'b0;
        end else if (w_exc_take) begin
            r_epc          <= r_pc;
            r_in_exception <= 1'b1;
        end else if (w_eret_take) begin
            r_in_exception <= 1'b0;
        end
    end
`else
    logic w_unused_exc;

    assign w_unused_exc = exc_req ^ eret;
    assign w_exc_take   = 1'b0;
    assign w_eret_take  = 1'b0;
    assign epc          = '0;
    assign in_exception = 1'b0;
`endif

    // Exception, eret and stall all pre-empt pc_control and cancel any RAS push/pop.
    always_comb begin
        w_pc_next = pc_plus_4;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        if (w_exc_take) begin
            w_pc_next = LP_EXC_PC;
        end else if (w_eret_take) begin
            w_pc_next = epc;
        end else if (stall) begin
            w_pc_next = r_pc;
        end else begin
            case (pc_control)
                3'b001: w_pc_next = w_jump_target;
                3'b010: w_pc_next = reg_address;
                3'b011: w_pc_next = w_branch_target;
                3'b100: begin
                    w_pc_next = w_jump_target;
                    w_push    = 1'b1;
                end
                3'b101: begin
                    w_pc_next = reg_address;
                    w_pop     = 1'b1;
                end
                default: w_pc_next = pc_plus_4;
            endcase
        end
    end

    assign w_mispredict_next = w_pop & ((r_count == '0) | (ras_top != reg_address));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= LP_RESET_PC;
            r_mispredict <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_mispredict <= w_mispredict_next;
        end
    end

    // A push when full overwrites the oldest slot, which is exactly where r_wptr points.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
            r_wptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_push) begin
            r_ras[r_wptr] <= pc_plus_4;
            r_wptr        <= w_wptr_inc;
            if (r_count == LP_DEPTH) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end else if (w_pop && (r_count != '0)) begin
            r_wptr  <= w_top_idx;
            r_count <= r_count - 1'b1;
        end
    end

endmodule
